// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding, the DIV opcode, and NZCV flag bit positions.
package alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

   localparam logic [2:0] ALUCTL_DIV = 3'b101;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_div_seq_step.sv
// Single combinational restoring-division iteration: shift in the next dividend bit,
// then subtract the divisor if that does not borrow.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_trial;

   // The shifted remainder keeps its top bit, so divisors >= 2^(WIDTH-1) cannot overflow the trial.
   assign w_shift = {i_rem, i_bit};
   assign w_trial = w_shift - {1'b0, i_div};
   assign o_qbit  = ~w_trial[WIDTH];
   assign o_rem   = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/alu_div_seq.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, NZCV flags.
// Define DIV_SIGNED_EN for two's-complement division (truncating toward zero).
module alu_div_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic [3:0]       DivFlags
);

   div_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic [3:0]       r_flags;

   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH-1:0] w_new_rem;
   logic             w_qbit;
   logic [WIDTH-1:0] w_quo_next;
   logic [WIDTH-1:0] w_q_res;
   logic [WIDTH-1:0] w_r_res;
   logic             w_v;
   logic [3:0]       w_flags;
   logic [3:0]       w_dz_flags;

`ifdef DIV_SIGNED_EN
   logic r_q_neg;
   logic r_r_neg;
   logic r_ovf;
   logic w_ovf;

   assign w_a_mag = a[WIDTH-1] ? -a : a;
   assign w_b_mag = b[WIDTH-1] ? -b : b;
   assign w_ovf   = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
   // Sign fix-up happens on the final step so the output load stays on the same edge.
   assign w_q_res = r_q_neg ? -w_quo_next : w_quo_next;
   assign w_r_res = r_r_neg ? -w_new_rem : w_new_rem;
   assign w_v     = r_ovf;
`else
   assign w_a_mag = a;
   assign w_b_mag = b;
   assign w_q_res = w_quo_next;
   assign w_r_res = w_new_rem;
   assign w_v     = 1'b0;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem  (r_rem),
      .i_bit  (r_quo[WIDTH-1]),
      .i_div  (r_div),
      .o_rem  (w_new_rem),
      .o_qbit (w_qbit)
   );

   assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};

   always_comb begin
      w_flags         = 4'b0000;
      w_flags[FLAG_N] = w_q_res[WIDTH-1];
      w_flags[FLAG_Z] = (w_q_res == '0);
      w_flags[FLAG_C] = 1'b0;
      w_flags[FLAG_V] = w_v;
   end

   always_comb begin
      w_dz_flags         = 4'b0000;
      w_dz_flags[FLAG_N] = 1'b1;
      w_dz_flags[FLAG_V] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_div       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_flags     <= 4'b0000;
`ifdef DIV_SIGNED_EN
         r_q_neg     <= 1'b0;
         r_r_neg     <= 1'b0;
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (b == '0) begin
                     r_quotient  <= '1;
                     r_remainder <= a;
                     r_flags     <= w_dz_flags;
                     r_state     <= ST_DONE;
                  end else begin
                     r_rem   <= '0;
                     r_quo   <= w_a_mag;
                     r_div   <= w_b_mag;
                     r_cnt   <= CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
                     r_q_neg <= a[WIDTH-1] ^ b[WIDTH-1];
                     r_r_neg <= a[WIDTH-1];
                     r_ovf   <= w_ovf;
`endif
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               r_rem <= w_new_rem;
               r_quo <= w_quo_next;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_quotient  <= w_q_res;
                  r_remainder <= w_r_res;
                  r_flags     <= w_flags;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_DONE);
   assign Quotient  = r_quotient;
   assign Remainder = r_remainder;
   assign DivFlags  = r_flags;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed and randomized bench for alu_div_seq against an arithmetic reference model.
module tb_alu_div_seq;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  Quotient;
   logic [W-1:0]  Remainder;
   logic [3:0]    DivFlags;

   int checks = 0;
   int errors = 0;

   alu_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .DivFlags  (DivFlags)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation timed out");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic [3:0] f);
      logic v;
      v = 1'b0;
      if (y == 0) begin
         q = 32'hFFFFFFFF;
         r = x;
         v = 1'b1;
      end
`ifdef DIV_SIGNED_EN
      else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
         q = 32'h80000000;
         r = 32'h0;
         v = 1'b1;
      end else begin
         q = $signed(x) / $signed(y);
         r = $signed(x) % $signed(y);
      end
`else
      else begin
         q = x / y;
         r = x % y;
      end
`endif
      f = {q[31], (q == 0), 1'b0, v};
   endfunction

   // Issue one division, inject ignored start/operand noise while busy, check result and latency.
   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string tag);
      logic [31:0] eq;
      logic [31:0] er;
      logic [3:0]  ef;
      int n;
      int lat;
      model(x, y, eq, er, ef);
      lat = (y == 0) ? 1 : W + 1;
      a = x;
      b = y;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      while (!done && n < 60) begin
         a = $urandom;
         b = $urandom;
         start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      check({tag, "_done"}, {31'b0, done}, 32'd1);
      check({tag, "_lat"}, n, lat);
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      check({tag, "_q"}, Quotient, eq);
      check({tag, "_r"}, Remainder, er);
      check({tag, "_f"}, {28'b0, DivFlags}, {28'b0, ef});
      @(posedge clk); #1;
      check({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
      check({tag, "_hold"}, Quotient, eq);
   endtask

   initial begin
      logic [31:0] eq;
      logic [31:0] er;
      logic [3:0]  ef;
      int          d_edges[$];
      int          e;
      int          d1;
      int          d2;
      logic        seen;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] ca[8];
      logic [31:0] cb[8];

      reset = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      #1;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_q", Quotient, 32'd0);
      check("rst_r", Remainder, 32'd0);
      check("rst_f", {28'b0, DivFlags}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      run_op(32'd100, 32'd7, "d100_7");
      check("d100_7_exact", Quotient, 32'd14);
      run_op(32'd5, 32'd0, "dz5");
      check("dz5_flags", {28'b0, DivFlags}, 32'h9);

      // start held high: one operation per 34 cycles
      model(32'hFFFFFFFF, 32'd1, eq, er, ef);
      a = 32'hFFFFFFFF;
      b = 32'd1;
      start = 1'b1;
      e = 0;
      while (d_edges.size() < 3 && e < 200) begin
         @(posedge clk); #1;
         e++;
         if (done) begin
            d_edges.push_back(e);
            check("held_q", Quotient, eq);
            check("held_r", Remainder, er);
            check("held_f", {28'b0, DivFlags}, {28'b0, ef});
         end
      end
      start = 1'b0;
      check("held_count", d_edges.size(), 32'd3);
      d1 = (d_edges.size() == 3) ? d_edges[1] - d_edges[0] : 0;
      d2 = (d_edges.size() == 3) ? d_edges[2] - d_edges[1] : 0;
      check("held_first", (d_edges.size() > 0) ? d_edges[0] : 0, 32'd33);
      check("held_period1", d1, 32'd34);
      check("held_period2", d2, 32'd34);
      @(posedge clk); #1;
      @(posedge clk); #1;

      run_op(32'd3, 32'd10, "d3_10");

      // abort a division with reset at cycle 15
      a = 32'd1000;
      b = 32'd3;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      check("abort_busy_pre", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("abort_q", Quotient, 32'd0);
      check("abort_r", Remainder, 32'd0);
      check("abort_f", {28'b0, DivFlags}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      seen = done;
      repeat (3) begin
         @(posedge clk); #1;
         seen = seen | done;
      end
      reset = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen = seen | done;
      end
      check("abort_nodone", {31'b0, seen}, 32'd0);
      run_op(32'd1000, 32'd3, "post_rst");

`ifdef DIV_SIGNED_EN
      run_op(-32'sd7, 32'd2, "s_m7_2");
      check("s_m7_2_q", Quotient, 32'hFFFFFFFD);
      check("s_m7_2_r", Remainder, 32'hFFFFFFFF);
      run_op(32'h80000000, 32'hFFFFFFFF, "s_ovf");
      check("s_ovf_v", {31'b0, DivFlags[0]}, 32'd1);
`endif

      ca = '{32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'd7};
      cb = '{32'd0, 32'd0, 32'd5, 32'hFFFFFFFF, 32'h80000001, 32'h80000000, 32'd1, 32'd8};
      for (int i = 0; i < 8; i++) run_op(ca[i], cb[i], $sformatf("corner%0d", i));

      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 15))
            0:       rb = 32'd0;
            1, 2, 3: rb = $urandom_range(1, 15);
            4, 5:    rb = $urandom | 32'h80000000;
            6:       rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         ra = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         run_op(ra, rb, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
